// File: rtl/alt_mem_phy_pll_pkg.sv
// Shared types and defaults for the PLL dynamic phase-step controller.
package alt_mem_phy_pll_pkg;

  localparam int unsigned DefClockIndexWidth  = 3;
  localparam int unsigned DefPllStepsPerCycle = 64;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StSetup,
    StStep,
    StWaitLow,
    StWaitHigh,
    StGap
  } phs_state_e;

endpackage

// File: rtl/alt_mem_phy_sync2.sv
// Two-flop synchroniser for an asynchronous level, with a selectable reset value.
module alt_mem_phy_sync2 #(
  parameter bit ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/alt_mem_phy_pll_phase_step_ctrl.sv
// Turns a sequencer phase-step request into a PLL phasestep handshake and tracks resync position.
// Define PLL_PHS_STEP_TIMEOUT_EN to add a phasedone watchdog and the phs_step_timeout output.
module alt_mem_phy_pll_phase_step_ctrl
  import alt_mem_phy_pll_pkg::*;
#(
  parameter int unsigned ClockIndexWidth  = DefClockIndexWidth,
  parameter int unsigned PllStepsPerCycle = DefPllStepsPerCycle,
  parameter int unsigned PosWidth         = 6,
  parameter int unsigned StepHoldCycles   = 2,
  parameter int unsigned GapCycles        = 2
`ifdef PLL_PHS_STEP_TIMEOUT_EN
  , parameter int unsigned TimeoutCycles  = 1024
`endif
) (
  input  logic                       seq_clk,
  input  logic                       reset_seq_n,
  input  logic                       seq_pll_start_reconfig,
  input  logic [ClockIndexWidth-1:0] seq_pll_select,
  input  logic                       seq_pll_inc_dec_n,
  input  logic [ClockIndexWidth-1:0] resync_clk_index,
  input  logic                       pll_locked,
  input  logic                       pll_phasedone,
  output logic [ClockIndexWidth-1:0] pll_phasecounterselect,
  output logic                       pll_phaseupdown,
  output logic                       pll_phasestep,
  output logic                       phs_shft_busy,
  output logic [PosWidth-1:0]        resync_phase_pos,
  output logic                       req_while_busy_err
`ifdef PLL_PHS_STEP_TIMEOUT_EN
  , output logic                     phs_step_timeout
`endif
);

  localparam int unsigned CntMax = (StepHoldCycles > GapCycles) ? StepHoldCycles : GapCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [PosWidth-1:0] PosMax = PosWidth'(PllStepsPerCycle - 1);

  logic lock_s, done_s;

  alt_mem_phy_sync2 #(.ResetVal(1'b0)) u_sync_lock (
    .clk_i  (seq_clk),
    .rst_ni (reset_seq_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  alt_mem_phy_sync2 #(.ResetVal(1'b1)) u_sync_done (
    .clk_i  (seq_clk),
    .rst_ni (reset_seq_n),
    .d_i    (pll_phasedone),
    .q_o    (done_s)
  );

  phs_state_e                 state_q;
  logic [CntW-1:0]            cnt_q;
  logic [ClockIndexWidth-1:0] sel_q;
  logic                       updown_q, step_q, busy_q, err_q;
  logic [PosWidth-1:0]        pos_q, pos_d;

`ifdef PLL_PHS_STEP_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt_q;
  logic           to_q;
`endif

  always_comb begin
    pos_d = pos_q;
    if (updown_q) begin
      pos_d = (pos_q == PosMax) ? '0 : pos_q + PosWidth'(1);
    end else begin
      pos_d = (pos_q == '0) ? PosMax : pos_q - PosWidth'(1);
    end
  end

  always_ff @(posedge seq_clk or negedge reset_seq_n) begin
    if (!reset_seq_n) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      sel_q    <= '0;
      updown_q <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
      pos_q    <= '0;
`ifdef PLL_PHS_STEP_TIMEOUT_EN
      to_cnt_q <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
`ifdef PLL_PHS_STEP_TIMEOUT_EN
      to_q <= 1'b0;
`endif
      // Lock loss takes priority: a simultaneous request is neither served nor flagged.
      if (seq_pll_start_reconfig && (state_q != StIdle) && lock_s) begin
        err_q <= 1'b1;
      end
      if (!lock_s) begin
        state_q <= StInit;
        step_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StInit: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          StIdle: begin
            if (seq_pll_start_reconfig) begin
              sel_q    <= seq_pll_select;
              updown_q <= seq_pll_inc_dec_n;
              busy_q   <= 1'b1;
              state_q  <= StSetup;
            end
          end
          StSetup: begin
            step_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StStep;
          end
          StStep: begin
            if (cnt_q == CntW'(StepHoldCycles - 1)) begin
              step_q  <= 1'b0;
              state_q <= StWaitLow;
`ifdef PLL_PHS_STEP_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StWaitLow, StWaitHigh: begin
`ifdef PLL_PHS_STEP_TIMEOUT_EN
            if (to_cnt_q == ToW'(TimeoutCycles - 1)) begin
              to_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= StGap;
            end else begin
              to_cnt_q <= to_cnt_q + ToW'(1);
`endif
              if (state_q == StWaitLow) begin
                if (!done_s) begin
                  state_q <= StWaitHigh;
                end
              end else if (done_s) begin
                if (sel_q == resync_clk_index) begin
                  pos_q <= pos_d;
                end
                cnt_q   <= '0;
                state_q <= StGap;
              end
`ifdef PLL_PHS_STEP_TIMEOUT_EN
            end
`endif
          end
          StGap: begin
            if (cnt_q == CntW'(GapCycles - 1)) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: state_q <= StInit;
        endcase
      end
    end
  end

  assign pll_phasecounterselect = sel_q;
  assign pll_phaseupdown        = updown_q;
  assign pll_phasestep          = step_q;
  assign phs_shft_busy          = busy_q;
  assign resync_phase_pos       = pos_q;
  assign req_while_busy_err     = err_q;
`ifdef PLL_PHS_STEP_TIMEOUT_EN
  assign phs_step_timeout       = to_q;
`endif

endmodule

// File: tb/tb_alt_mem_phy_pll_phase_step_ctrl.sv
// Directed bench for the PLL phase-step controller with a small behavioural phasedone model.
module tb_alt_mem_phy_pll_phase_step_ctrl;

  logic       seq_clk;
  logic       reset_seq_n;
  logic       seq_pll_start_reconfig;
  logic [2:0] seq_pll_select;
  logic       seq_pll_inc_dec_n;
  logic [2:0] resync_clk_index;
  logic       pll_locked;
  logic       pll_phasedone;
  logic [2:0] pll_phasecounterselect;
  logic       pll_phaseupdown;
  logic       pll_phasestep;
  logic       phs_shft_busy;
  logic [5:0] resync_phase_pos;
  logic       req_while_busy_err;
`ifdef PLL_PHS_STEP_TIMEOUT_EN
  logic       phs_step_timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_pos  = 0;
  int ps_pulses = 0;
  int ps_len    = 0;
  bit ps_prev;
  bit model_en;

  alt_mem_phy_pll_phase_step_ctrl #(
    .ClockIndexWidth  (3),
    .PllStepsPerCycle (64),
    .PosWidth         (6),
    .StepHoldCycles   (2),
    .GapCycles        (2)
`ifdef PLL_PHS_STEP_TIMEOUT_EN
    , .TimeoutCycles  (16)
`endif
  ) dut (
    .seq_clk                (seq_clk),
    .reset_seq_n            (reset_seq_n),
    .seq_pll_start_reconfig (seq_pll_start_reconfig),
    .seq_pll_select         (seq_pll_select),
    .seq_pll_inc_dec_n      (seq_pll_inc_dec_n),
    .resync_clk_index       (resync_clk_index),
    .pll_locked             (pll_locked),
    .pll_phasedone          (pll_phasedone),
    .pll_phasecounterselect (pll_phasecounterselect),
    .pll_phaseupdown        (pll_phaseupdown),
    .pll_phasestep          (pll_phasestep),
    .phs_shft_busy          (phs_shft_busy),
    .resync_phase_pos       (resync_phase_pos),
    .req_while_busy_err     (req_while_busy_err)
`ifdef PLL_PHS_STEP_TIMEOUT_EN
    , .phs_step_timeout     (phs_step_timeout)
`endif
  );

  initial begin
    seq_clk = 1'b0;
    forever #5 seq_clk = ~seq_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  // PLL model: phasedone drops 3 cycles after phasestep falls and stays low for 5 cycles.
  initial begin
    forever begin
      @(negedge pll_phasestep);
      if (model_en) begin
        repeat (3) @(posedge seq_clk);
        #1 pll_phasedone = 1'b0;
        repeat (5) @(posedge seq_clk);
        #1 pll_phasedone = 1'b1;
      end
    end
  end

  // Counts phasestep pulses and the length of the most recent one.
  initial begin
    forever begin
      @(posedge seq_clk);
      #2;
      if (pll_phasestep === 1'b1) begin
        if (!ps_prev) begin
          ps_pulses++;
          ps_len = 0;
        end
        ps_len++;
      end
      ps_prev = (pll_phasestep === 1'b1);
    end
  end

  task automatic tick();
    @(posedge seq_clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] sel, input logic inc, input int exp_lat,
                        input int misuse_at);
    int   n;
    int   p0;
    logic stable;
    p0 = ps_pulses;
    seq_pll_select         = sel;
    seq_pll_inc_dec_n      = inc;
    seq_pll_start_reconfig = 1'b1;
    tick();
    seq_pll_start_reconfig = 1'b0;
    check_eq("busy_rise", phs_shft_busy, 1);
    n      = 0;
    stable = 1'b1;
    while (phs_shft_busy && n < 100) begin
      if (pll_phasecounterselect !== sel || pll_phaseupdown !== inc) stable = 1'b0;
      if (n == misuse_at) begin
        seq_pll_start_reconfig = 1'b1;
        seq_pll_select         = ~sel;
        seq_pll_inc_dec_n      = ~inc;
      end
      tick();
      seq_pll_start_reconfig = 1'b0;
      n++;
    end
    check_eq("req_complete", (n < 100), 1);
    if (exp_lat > 0) check_eq("busy_latency", n, exp_lat);
    check_eq("sel_updown_stable", stable, 1);
    check_eq("step_pulses", ps_pulses - p0, 1);
    check_eq("step_len", ps_len, 2);
    if (sel == resync_clk_index) exp_pos = inc ? (exp_pos + 1) % 64 : (exp_pos + 63) % 64;
    check_eq("pos", resync_phase_pos, exp_pos);
  endtask

  initial begin
    reset_seq_n            = 1'b0;
    pll_locked             = 1'b0;
    pll_phasedone          = 1'b1;
    seq_pll_start_reconfig = 1'b0;
    seq_pll_select         = 3'd0;
    seq_pll_inc_dec_n      = 1'b0;
    resync_clk_index       = 3'd3;
    repeat (3) tick();
    check_eq("rst_busy", phs_shft_busy, 1);
    check_eq("rst_step", pll_phasestep, 0);
    check_eq("rst_updown", pll_phaseupdown, 0);
    check_eq("rst_sel", pll_phasecounterselect, 0);
    check_eq("rst_pos", resync_phase_pos, 0);
    check_eq("rst_err", req_while_busy_err, 0);

    reset_seq_n = 1'b1;
    repeat (3) tick();
    check_eq("init_no_lock", phs_shft_busy, 1);
    pll_locked = 1'b1;
    model_en   = 1'b1;
    repeat (2) tick();
    check_eq("lock_sync_busy", phs_shft_busy, 1);
    tick();
    check_eq("lock_idle", phs_shft_busy, 0);

    do_req(3'd3, 1'b1, 16, -1);
    for (int i = 0; i < 63; i++) do_req(3'd3, 1'b1, 0, -1);
    check_eq("wrap_up_pos", resync_phase_pos, 0);
    do_req(3'd3, 1'b0, 0, -1);
    check_eq("wrap_down_pos", resync_phase_pos, 63);

    do_req(3'd2, 1'b1, 0, -1);
    check_eq("untracked_pos", resync_phase_pos, 63);
    check_eq("err_clean", req_while_busy_err, 0);

    do_req(3'd3, 1'b0, 0, 3);
    check_eq("misuse_err", req_while_busy_err, 1);

    // Lock loss in WAIT_HIGH: the step must not complete or count.
    seq_pll_select         = 3'd3;
    seq_pll_inc_dec_n      = 1'b1;
    seq_pll_start_reconfig = 1'b1;
    tick();
    seq_pll_start_reconfig = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b0;
    repeat (9) tick();
    check_eq("lockloss_busy", phs_shft_busy, 1);
    check_eq("lockloss_pos", resync_phase_pos, exp_pos);
    check_eq("lockloss_step", pll_phasestep, 0);
    check_eq("lockloss_sel_hold", pll_phasecounterselect, 3);
    pll_locked = 1'b1;
    repeat (2) tick();
    check_eq("relock_busy", phs_shft_busy, 1);
    tick();
    check_eq("relock_idle", phs_shft_busy, 0);
    check_eq("relock_pos", resync_phase_pos, exp_pos);

`ifdef PLL_PHS_STEP_TIMEOUT_EN
    begin
      int n;
      int to_at;
      int to_cnt;
      model_en               = 1'b0;
      seq_pll_select         = 3'd3;
      seq_pll_inc_dec_n      = 1'b1;
      seq_pll_start_reconfig = 1'b1;
      tick();
      seq_pll_start_reconfig = 1'b0;
      n      = 0;
      to_at  = -1;
      to_cnt = 0;
      while (phs_shft_busy && n < 60) begin
        if (phs_step_timeout) begin
          to_cnt++;
          if (to_at < 0) to_at = n;
        end
        tick();
        n++;
      end
      check_eq("timeout_at", to_at, 19);
      check_eq("timeout_width", to_cnt, 1);
      check_eq("timeout_busy_low", n, 21);
      check_eq("timeout_pos", resync_phase_pos, exp_pos);
      model_en = 1'b1;
    end
`endif

    // Reset in the middle of a step returns everything to reset values.
    seq_pll_select         = 3'd3;
    seq_pll_inc_dec_n      = 1'b1;
    seq_pll_start_reconfig = 1'b1;
    tick();
    seq_pll_start_reconfig = 1'b0;
    repeat (4) tick();
    reset_seq_n = 1'b0;
    #1;
    check_eq("midrst_busy", phs_shft_busy, 1);
    check_eq("midrst_pos", resync_phase_pos, 0);
    check_eq("midrst_err", req_while_busy_err, 0);
    check_eq("midrst_sel", pll_phasecounterselect, 0);
    check_eq("midrst_updown", pll_phaseupdown, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
